// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_master_byte command port between N_REQ requesters.
// Ownership is held for a whole START..STOP transaction; a watchdog forces STOP on a stalled owner.
module i2c_cmd_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_REQ-1:0]            req_start_i,
  input  logic [N_REQ-1:0]            req_stop_i,
  input  logic [N_REQ-1:0]            req_read_i,
  input  logic [N_REQ-1:0]            req_write_i,
  input  logic [N_REQ-1:0]            req_ack_in_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_din_i,
  output logic [DATA_WIDTH-1:0]       req_dout_o,
  output logic [N_REQ-1:0]            req_cmd_ack_o,
  output logic                        m_start_o,
  output logic                        m_stop_o,
  output logic                        m_read_o,
  output logic                        m_write_o,
  output logic                        m_ack_in_o,
  output logic [DATA_WIDTH-1:0]       m_din_o,
  input  logic [DATA_WIDTH-1:0]       m_dout_i,
  input  logic                        m_cmd_ack_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWNED,
    ST_BUSY,
    ST_HOLD,
    ST_FSTOP
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pend, cand;
  logic             own_start, own_stop, own_read, own_write, own_ack_in, own_pend;
  logic [DATA_WIDTH-1:0] own_din;

  assign pend = req_read_i | req_write_i | req_stop_i;
  assign cand = pend & req_start_i;

  assign own_start  = req_start_i[owner_q];
  assign own_stop   = req_stop_i[owner_q];
  assign own_read   = req_read_i[owner_q];
  assign own_write  = req_write_i[owner_q];
  assign own_ack_in = req_ack_in_i[owner_q];
  assign own_pend   = pend[owner_q];
  assign own_din    = req_din_i[owner_q*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin: first START-bearing candidate after the previous owner, wrapping.
  logic          found;
  logic [IW-1:0] pick;
  int unsigned   idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!found && cand[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    grant_d       = grant_q;
    cnt_d         = '0;
    timeout_d     = 1'b0;
    m_start_o     = 1'b0;
    m_stop_o      = 1'b0;
    m_read_o      = 1'b0;
    m_write_o     = 1'b0;
    m_ack_in_o    = 1'b0;
    m_din_o       = '0;
    req_cmd_ack_o = '0;
    req_dout_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = ST_OWNED;
        end
      end
      ST_OWNED: begin
        m_start_o  = own_start;
        m_stop_o   = own_stop;
        m_read_o   = own_read;
        m_write_o  = own_write;
        m_ack_in_o = own_ack_in;
        m_din_o    = own_din;
        // A pending command beats a coincident watchdog expiry.
        if (own_pend) begin
          state_d = ST_BUSY;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FSTOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        m_start_o  = own_start;
        m_stop_o   = own_stop;
        m_read_o   = own_read;
        m_write_o  = own_write;
        m_ack_in_o = own_ack_in;
        m_din_o    = own_din;
        if (m_cmd_ack_i) begin
          req_cmd_ack_o = grant_q;
          req_dout_o    = m_dout_i;
          if (own_stop) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
            grant_d = '0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        m_ack_in_o = own_ack_in;
        m_din_o    = own_din;
        state_d    = ST_OWNED;
      end
      ST_FSTOP: begin
        m_stop_o = 1'b1;
        if (m_cmd_ack_i) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          last_d    = owner_q;
          grant_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= IW'(N_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign timeout_o = timeout_q;

endmodule
